// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO in front of the UART transmitter.
// Bytes written by the core are queued. One byte at a time is moved into the
// d_out register, a one-cycle tx_start pulse is issued, and d_out is held
// until the transmitter answers with tx_done.
module uart_tx_feeder #(
    parameter  int BITS_PER_DATA = 8,
    parameter  int FIFO_DEPTH    = 16,
    localparam int ADDR_W        = $clog2(FIFO_DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [BITS_PER_DATA-1:0] wr_data,
    input  logic                     flush,
    input  logic                     tx_done,
    output logic                     tx_start,
    output logic [BITS_PER_DATA-1:0] d_out,
    output logic                     busy,
    output logic                     full,
    output logic                     empty,
    output logic [ADDR_W:0]          count,
    output logic                     overflow
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } state_t;

    state_t                   state_reg;
    state_t                   state_next;

    logic [BITS_PER_DATA-1:0] mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]        rd_ptr_reg;
    logic [ADDR_W-1:0]        wr_ptr_reg;
    logic [ADDR_W:0]          count_reg;
    logic [BITS_PER_DATA-1:0] d_out_reg;
    logic                     overflow_reg;

    logic                     pop;
    logic                     push;
    logic                     drop;

    // The only pop happens while the FSM sits in LOAD. A write into a full
    // FIFO still fits when a pop frees a slot on the same edge. flush wins
    // over any write and never counts as a drop.
    assign pop  = (state_reg == LOAD);
    assign push = wr_en && !flush && (!full || pop);
    assign drop = wr_en && !flush && full && !pop;

    assign full     = (count_reg == DEPTH_CNT);
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign d_out    = d_out_reg;
    assign overflow = overflow_reg;

    // State register; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and Moore outputs. tx_done is only honoured in WAIT.
    always_comb begin
        state_next = state_reg;
        tx_start   = 1'b0;
        busy       = 1'b1;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (!empty && !flush) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = START;
            end
            START: begin
                tx_start   = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (tx_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else if (flush) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Output byte register: loaded only in LOAD, even if a flush lands there,
    // so the frame already started completes with the right data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_out_reg <= '0;
        end else if (pop) begin
            d_out_reg <= mem[rd_ptr_reg];
        end
    end

    // Storage array; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: reset, single byte, burst, overflow,
// full-with-pop, flush and asynchronous reset mid-frame.
module tb_uart_tx_feeder;

    localparam int W  = 8;
    localparam int AW = 4;

    logic          clk     = 1'b0;
    logic          reset   = 1'b0;
    logic          wr_en   = 1'b0;
    logic [W-1:0]  wr_data = '0;
    logic          flush   = 1'b0;
    logic          tx_done = 1'b0;
    logic          tx_start;
    logic [W-1:0]  d_out;
    logic          busy;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;

    uart_tx_feeder #(.BITS_PER_DATA(W), .FIFO_DEPTH(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .flush    (flush),
        .tx_done  (tx_done),
        .tx_start (tx_start),
        .d_out    (d_out),
        .busy     (busy),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every cycle with tx_start high, together with d_out and the cycle.
    logic [W-1:0] start_q[$];
    int           start_cyc[$];
    int           max_count = 0;
    bit           track_max = 1'b0;
    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            start_q.push_back(d_out);
            start_cyc.push_back(cyc);
        end
        if (track_max && (int'(count) > max_count)) max_count = int'(count);
    end

    int n_vec = 0;
    int n_err = 0;
    int done_cyc = 0;
    int wcyc = 0;
    int base = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_starts(input int target, input int budget);
        int k = 0;
        while (start_q.size() < target && k < budget) begin
            step();
            k++;
        end
        check("start_seen", start_q.size(), target);
    endtask

    task automatic pulse_done();
        tx_done  = 1'b1;
        done_cyc = cyc;
        step();
        tx_done  = 1'b0;
    endtask

    task automatic write_bytes(input logic [W-1:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = first + W'(i);
            step();
        end
        wr_en = 1'b0;
    endtask

    // Wait for frames idx from..to-1 of a sequence starting at first_val,
    // check each byte and answer with tx_done a few cycles later.
    task automatic drain(input int b, input logic [W-1:0] first_val, input int from, input int to);
        for (int i = from; i < to; i++) begin
            wait_starts(b + i + 1, 40);
            if (start_q.size() > b + i)
                check("drain_data", start_q[b + i], first_val + W'(i));
            step(3);
            pulse_done();
        end
    endtask

    initial begin
        // Reset and idle
        step(3);
        check("rst_tx_start", tx_start, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_d_out", d_out, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        reset = 1'b1;
        step(6);
        check("idle_no_start", start_q.size(), 0);
        check("idle_empty", empty, 1);

        // Single byte: tx_start in the 3rd cycle after the write edge, i.e.
        // two cycles after the cycle that follows the write edge.
        wr_en = 1'b1; wr_data = 8'hA5;
        step();
        wr_en = 1'b0;
        wcyc = cyc;
        check("single_count_after_wr", count, 1);
        wait_starts(1, 10);
        if (start_q.size() > 0) begin
            check("single_latency", start_cyc[0] - wcyc, 2);
            check("single_data", start_q[0], 8'hA5);
        end
        check("single_pulse_ended", tx_start, 0);
        check("single_count_zero", count, 0);
        step(4);
        check("single_hold_d_out", d_out, 8'hA5);
        check("single_busy_wait", busy, 1);
        pulse_done();
        check("single_busy_fall", busy, 0);
        check("single_empty", empty, 1);
        check("single_d_out_kept", d_out, 8'hA5);
        step(6);
        check("single_no_extra", start_q.size(), 1);

        // Burst 0x01..0x05, tx_done 200 cycles after each tx_start
        base = start_q.size();
        max_count = 0;
        track_max = 1'b1;
        write_bytes(8'h01, 5);
        for (int i = 0; i < 5; i++) begin
            wait_starts(base + i + 1, 300);
            if (start_q.size() > base + i) begin
                check("burst_data", start_q[base + i], 8'h01 + W'(i));
                if (i > 0) check("burst_gap", start_cyc[base + i] - done_cyc, 3);
            end
            step(199);
            pulse_done();
        end
        track_max = 1'b0;
        check("burst_peak_count", max_count, 4);
        check("burst_total", start_q.size(), base + 5);

        // Overflow: 18 writes with the transmitter stalled
        base = start_q.size();
        write_bytes(8'h10, 18);
        check("ovf_full", full, 1);
        check("ovf_count", count, 16);
        check("ovf_flag", overflow, 1);
        check("ovf_in_flight", start_q.size(), base + 1);
        drain(base, 8'h10, 0, 17);
        step(10);
        check("ovf_drained_total", start_q.size(), base + 17);
        check("ovf_drained_empty", empty, 1);
        check("ovf_sticky", overflow, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_clears_ovf", overflow, 0);

        // Full FIFO with a write landing on the LOAD cycle
        base = start_q.size();
        write_bytes(8'h40, 17);
        check("fp_full", full, 1);
        check("fp_count_pre", count, 16);
        pulse_done();        // now in IDLE
        step();              // now in LOAD
        wr_en = 1'b1; wr_data = 8'h51;
        step();
        wr_en = 1'b0;
        check("fp_count", count, 16);
        check("fp_full_after", full, 1);
        check("fp_no_overflow", overflow, 0);
        drain(base, 8'h40, 1, 18);
        step(10);
        check("fp_total", start_q.size(), base + 18);
        check("fp_empty", empty, 1);

        // flush in WAIT with 3 bytes queued, plus a simultaneous write
        base = start_q.size();
        write_bytes(8'h60, 4);
        check("fl_count_pre", count, 3);
        step(2);
        flush = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
        step();
        flush = 1'b0; wr_en = 1'b0;
        check("fl_count", count, 0);
        check("fl_empty", empty, 1);
        check("fl_overflow", overflow, 0);
        check("fl_busy", busy, 1);
        check("fl_d_out", d_out, 8'h60);
        step(2);
        pulse_done();
        step(20);
        check("fl_no_more_starts", start_q.size(), base + 1);
        check("fl_idle", busy, 0);

        // Asynchronous reset while in WAIT
        base = start_q.size();
        write_bytes(8'h70, 2);
        wait_starts(base + 1, 10);
        step(2);
        check("rm_busy_pre", busy, 1);
        #2 reset = 1'b0;
        #1;
        check("rm_busy", busy, 0);
        check("rm_d_out", d_out, 0);
        check("rm_count", count, 0);
        check("rm_empty", empty, 1);
        check("rm_tx_start", tx_start, 0);
        step(2);
        reset = 1'b1;
        step(20);
        check("rm_no_start", start_q.size(), base + 1);
        check("rm_empty_after", empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
